move_sequencer: RTL and testbench

- Parametrised successor to the stepper processor's MOVR/MOVRHS/PAUSE micro-sequencing, as a standalone block.
- Accepts one move or pause command per handshake and steps an internal position register toward a signed target count, full-step (±2) or half-step (±1).
- Enforces a programmable inter-step delay, supports abort, and reports progress.
- Sits between the instruction controller and the stepper phase decoder.

---
 rtl/move_sequencer_if.sv | 36 +++
 rtl/move_sequencer.sv | 153 +++++++++++++++
 tb/tb_move_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_sequencer_if.sv
// Command/status bundle between the instruction controller (master) and the
// move sequencer (slave).
interface move_sequencer_if #(
    parameter int COUNT_W = 8,
    parameter int DELAY_W = 20,
    parameter int POS_W   = 8
);
    // Handshake: a command transfers on the clk edge where cmd_valid && cmd_ready;
    // cmd_op/cmd_count/delay_period must be stable whenever cmd_valid is high,
    // and cmd_ready is only asserted while the sequencer is idle.
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [COUNT_W-1:0] cmd_count;
    logic [DELAY_W-1:0] delay_period;
    logic               abort;
    logic [POS_W-1:0]   position;
    logic               direction;
    logic               step_pulse;
    logic [COUNT_W-1:0] remaining;
    logic               busy;
    logic               done;
    logic               aborted;

    modport master (
        output cmd_valid, cmd_op, cmd_count, delay_period, abort,
        input  cmd_ready, position, direction, step_pulse, remaining,
               busy, done, aborted
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, delay_period, abort,
        output cmd_ready, position, direction, step_pulse, remaining,
               busy, done, aborted
    );
endinterface

// File: rtl/move_sequencer.sv
// Move/pause micro-sequencer: steps a wrapping position register toward a
// signed step count with a programmable inter-step delay and abort.
module move_sequencer #(
    parameter int COUNT_W = 8,
    parameter int DELAY_W = 20,
    parameter int POS_W   = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    move_sequencer_if.slave bus,
    output logic [2:0]      state_o
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_STEP       = 3'd1,
        S_WAIT       = 3'd2,
        S_PAUSE_WAIT = 3'd3,
        S_DONE       = 3'd4
    } state_t;

    localparam logic [1:0] OP_FULL  = 2'b00;
    localparam logic [1:0] OP_HALF  = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   position_q, position_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;
    logic               direction_q, direction_d;
    logic [DELAY_W-1:0] counter_q, counter_d;
    logic [DELAY_W-1:0] period_q, period_d;
    logic               mode_q, mode_d;
    logic               aborted_q, aborted_d;
    logic               step_pulse;
    logic [POS_W-1:0]   inc;
    logic [COUNT_W-1:0] rem_toward_zero;

    // mode_q = 1 selects half-stepping.
    assign inc = mode_q ? POS_W'(1) : POS_W'(2);

    // Moving toward zero by sign means -2^(COUNT_W-1) can never overflow.
    assign rem_toward_zero = remaining_q[COUNT_W-1] ? remaining_q + COUNT_W'(1)
                                                    : remaining_q - COUNT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            position_q  <= '0;
            remaining_q <= '0;
            direction_q <= 1'b0;
            counter_q   <= '0;
            period_q    <= '0;
            mode_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            position_q  <= position_d;
            remaining_q <= remaining_d;
            direction_q <= direction_d;
            counter_q   <= counter_d;
            period_q    <= period_d;
            mode_q      <= mode_d;
            aborted_q   <= aborted_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        position_d  = position_q;
        remaining_d = remaining_q;
        direction_d = direction_q;
        counter_d   = counter_q;
        period_d    = period_q;
        mode_d      = mode_q;
        aborted_d   = aborted_q;
        step_pulse  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    aborted_d = 1'b0;
                    case (bus.cmd_op)
                        OP_FULL, OP_HALF: begin
                            mode_d      = bus.cmd_op[0];
                            period_d    = bus.delay_period;
                            remaining_d = bus.cmd_count;
                            direction_d = bus.cmd_count[COUNT_W-1];
                            state_d     = S_STEP;
                        end
                        OP_PAUSE: begin
                            period_d  = bus.delay_period;
                            counter_d = bus.delay_period;
                            state_d   = S_PAUSE_WAIT;
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end

            S_STEP: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (remaining_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    step_pulse  = 1'b1;
                    position_d  = direction_q ? position_q - inc : position_q + inc;
                    remaining_d = rem_toward_zero;
                    counter_d   = period_q;
                    state_d     = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (counter_q == '0) begin
                    state_d = S_STEP;
                end else begin
                    counter_d = counter_q - DELAY_W'(1);
                end
            end

            S_PAUSE_WAIT: begin
                if (bus.abort) begin
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else if (counter_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    counter_d = counter_q - DELAY_W'(1);
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.step_pulse = step_pulse;
    assign bus.position   = position_q;
    assign bus.remaining  = remaining_q;
    assign bus.direction  = direction_q;
    assign bus.aborted    = aborted_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Bench for move_sequencer: table of commands with a per-step scoreboard,
// plus hand sequences for abort, reset and back-to-back handshakes.
module tb_move_sequencer;

    localparam int COUNT_W = 8;
    localparam int DELAY_W = 20;
    localparam int POS_W   = 8;
    localparam int POS_MASK = (1 << POS_W) - 1;

    logic       clk;
    logic       reset_n;
    logic [2:0] state_o;

    move_sequencer_if #(.COUNT_W(COUNT_W), .DELAY_W(DELAY_W), .POS_W(POS_W)) bus ();

    move_sequencer #(.COUNT_W(COUNT_W), .DELAY_W(DELAY_W), .POS_W(POS_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .state_o (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [COUNT_W+POS_W-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int pulse_cnt = 0;
    int last_cyc = -1;
    int exp_gap = 0;
    int model_pos = 0;
    logic pulse_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_step(input int rem, input int pos);
        logic [COUNT_W-1:0] r8;
        logic [POS_W-1:0]   p8;
        r8 = rem[COUNT_W-1:0];
        p8 = pos[POS_W-1:0];
        exp_q.push_back({r8, p8});
    endtask

    // Position/remaining become visible the cycle after each step pulse.
    always @(negedge clk) begin
        if (pulse_prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual=pulse expected=none (t=%0t)", $time);
            end else begin
                chk("step_result", {16'd0, bus.remaining, bus.position}, {16'd0, exp_q.pop_front()});
            end
        end
        pulse_prev = bus.step_pulse;
        if (bus.step_pulse) begin
            if (last_cyc >= 0) chk("pulse_gap", cyc - last_cyc, exp_gap);
            last_cyc = cyc;
            pulse_cnt++;
        end
    end

    // ---------------- driver ----------------
    typedef struct {
        logic [1:0] op;
        int         count;
        int         period;
        int         lat;
        int         pulses;
        int         pos;
        int         rem;
        bit         chk_dir;
        bit         dir;
        bit         abort_acc;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [1:0] op, input int count, input int period);
        int steps;
        int p;
        int r;
        exp_gap   = period + 2;
        last_cyc  = -1;
        pulse_cnt = 0;
        if (op == 2'b00 || op == 2'b01) begin
            steps = (count < 0) ? -count : count;
            p = model_pos;
            r = count;
            for (int i = 0; i < steps; i++) begin
                p = (count < 0) ? p - ((op == 2'b00) ? 2 : 1) : p + ((op == 2'b00) ? 2 : 1);
                p = p & POS_MASK;
                r = (r < 0) ? r + 1 : r - 1;
                push_step(r, p);
            end
        end
        bus.cmd_valid    = 1'b1;
        bus.cmd_op       = op;
        bus.cmd_count    = COUNT_W'(count);
        bus.delay_period = DELAY_W'(period);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int k;
        chk($sformatf("r%0d_ready_before", idx), bus.cmd_ready, 1);
        start_cmd(v.op, v.count, v.period);
        bus.abort = v.abort_acc;
        tick();
        bus.cmd_valid = 1'b0;
        bus.abort     = 1'b0;
        k = 1;
        chk($sformatf("r%0d_busy", idx), bus.busy, 1);
        while (!bus.done && k < 400) begin
            tick();
            k++;
        end
        chk($sformatf("r%0d_latency", idx), k, v.lat);
        chk($sformatf("r%0d_aborted", idx), bus.aborted, 0);
        chk($sformatf("r%0d_position", idx), bus.position, v.pos);
        chk($sformatf("r%0d_remaining", idx), bus.remaining, v.rem);
        if (v.chk_dir) chk($sformatf("r%0d_direction", idx), bus.direction, v.dir);
        chk($sformatf("r%0d_pulses", idx), pulse_cnt, v.pulses);
        chk($sformatf("r%0d_queue_empty", idx), exp_q.size(), 0);
        model_pos = v.pos;
        tick();
        chk($sformatf("r%0d_done_width", idx), bus.done, 0);
        chk($sformatf("r%0d_ready_after", idx), bus.cmd_ready, 1);
    endtask

    task automatic wait_pulses(input int n);
        int k;
        k = 0;
        while (pulse_cnt < n && k < 100) begin
            tick();
            k++;
        end
        chk("pulse_wait", pulse_cnt, n);
    endtask

    // ---------------- test ----------------
    initial begin
        //              op     cnt  P   lat  pls pos  rem chkd dir ab
        vecs[0] = '{2'b00,    3,  3,  17,   3,   6, 0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{2'b01,   -2,  0,   6,   2,   4, 0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{2'b10,    5, 10,  12,   0,   4, 0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{2'b11,    7,  4,   1,   0,   4, 0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{2'b00,    0,  5,   2,   0,   4, 0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{2'b00,   -2,  1,   8,   2,   0, 0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{2'b00,   -1,  0,   4,   1, 254, 0, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{2'b01, -128,  0, 258, 128, 126, 0, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{2'b00,   65,  0, 132,  65,   0, 0, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{2'b01,    3,  2,  14,   3,   3, 0, 1'b1, 1'b0, 1'b1};

        reset_n          = 1'b0;
        bus.cmd_valid    = 1'b0;
        bus.cmd_op       = 2'b00;
        bus.cmd_count    = '0;
        bus.delay_period = '0;
        bus.abort        = 1'b0;
        repeat (3) tick();
        chk("rst_state", state_o, 0);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_pulse", bus.step_pulse, 0);
        chk("rst_position", bus.position, 0);
        chk("rst_remaining", bus.remaining, 0);
        chk("rst_direction", bus.direction, 0);
        chk("rst_aborted", bus.aborted, 0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Abort while idle does nothing.
        bus.abort = 1'b1;
        repeat (3) begin
            tick();
            chk("idle_abort_busy", bus.busy, 0);
            chk("idle_abort_done", bus.done, 0);
        end
        bus.abort = 1'b0;
        chk("idle_abort_position", bus.position, 3);
        chk("idle_abort_aborted", bus.aborted, 0);

        // Reset in the middle of a move: straight to idle, no done.
        start_cmd(2'b00, 5, 3);
        exp_q.delete();
        push_step(4, 5);
        tick();
        bus.cmd_valid = 1'b0;
        wait_pulses(1);
        chk("midrst_in_wait", state_o, 2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midrst_state", state_o, 0);
        chk("midrst_position", bus.position, 0);
        chk("midrst_remaining", bus.remaining, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_ready", bus.cmd_ready, 1);
        model_pos = 0;
        tick();
        chk("midrst_done_after", bus.done, 0);

        // Abort during WAIT after two pulses of a +5 full-step move.
        start_cmd(2'b00, 5, 3);
        exp_q.delete();
        push_step(4, 2);
        push_step(3, 4);
        tick();
        bus.cmd_valid = 1'b0;
        wait_pulses(2);
        chk("wabort_in_wait", state_o, 2);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("wabort_done", bus.done, 1);
        chk("wabort_aborted", bus.aborted, 1);
        chk("wabort_remaining", bus.remaining, 3);
        chk("wabort_position", bus.position, 4);
        chk("wabort_queue_empty", exp_q.size(), 0);
        tick();
        chk("wabort_done_width", bus.done, 0);
        chk("wabort_aborted_hold", bus.aborted, 1);
        chk("wabort_ready", bus.cmd_ready, 1);
        model_pos = 4;

        // Abort landing on a STEP cycle wins over the step.
        start_cmd(2'b00, 3, 1);
        exp_q.delete();
        push_step(2, 6);
        tick();
        bus.cmd_valid = 1'b0;
        repeat (3) tick();
        chk("sabort_in_step", state_o, 1);
        bus.abort = 1'b1;
        #1;
        chk("sabort_no_pulse", bus.step_pulse, 0);
        tick();
        bus.abort = 1'b0;
        chk("sabort_done", bus.done, 1);
        chk("sabort_aborted", bus.aborted, 1);
        chk("sabort_position", bus.position, 6);
        chk("sabort_remaining", bus.remaining, 2);
        chk("sabort_pulses", pulse_cnt, 1);
        tick();

        // cmd_valid held through DONE: next accept only on the idle cycle.
        start_cmd(2'b11, 0, 0);
        exp_q.delete();
        tick();
        chk("hold_done1", bus.done, 1);
        chk("hold_ready_in_done", bus.cmd_ready, 0);
        chk("hold_aborted_cleared", bus.aborted, 0);
        tick();
        chk("hold_idle_done", bus.done, 0);
        chk("hold_idle_ready", bus.cmd_ready, 1);
        tick();
        chk("hold_done2", bus.done, 1);
        bus.cmd_valid = 1'b0;
        tick();
        chk("hold_final_ready", bus.cmd_ready, 1);
        chk("hold_final_done", bus.done, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
